// File: rtl/bootdata_streamer.sv
// rtl/bootdata_streamer.sv - host-side ROM boot-data streamer over a four-phase req/ack link
//
// Purpose:
//   On a start pulse, holds host_reset high for RESET_CYCLES cycles. It then
//   fetches ROM_BYTES/4 words from a word-addressed source. Each word goes to
//   the bootloader over a four-phase handshake (req up, ack up, req down,
//   ack down). If an ack edge does not arrive within ACK_TIMEOUT cycles, the
//   streamer aborts into ERROR.
//
// Ports:
//   clk                clock, rising edge
//   reset              synchronous, active-high; returns to IDLE
//   start              single-cycle start pulse; honoured only in IDLE/DONE/ERROR
//   src_addr[12:0]     word address presented with src_rd
//   src_rd             one-cycle read strobe to the source
//   src_valid          one-cycle pulse qualifying src_data
//   src_data[31:0]     fetched word (byte 0 in [7:0])
//   host_bootdata      word presented to the bootloader
//   host_bootdata_req  request line
//   host_bootdata_ack  acknowledge line, may be asynchronous to clk
//   host_reset         bootloader reset / address restart
//   busy, done, error  status

module bootdata_streamer #(
    parameter int ROM_BYTES    = 32768,
    parameter int RESET_CYCLES = 16,
    parameter int ACK_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [12:0] src_addr,
    output logic        src_rd,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic [31:0] host_bootdata,
    output logic        host_bootdata_req,
    input  logic        host_bootdata_ack,
    output logic        host_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          NWORDS   = ROM_BYTES / 4;
    localparam logic [12:0] LAST_IDX = 13'(NWORDS - 1);
    localparam int          RW       = $clog2(RESET_CYCLES + 1);
    localparam int          TW       = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_FETCH,
        S_WAIT_SRC,
        S_REQ,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] to_cnt;
    logic [12:0]   idx;

    // Two-flop synchronizer. The FSM only ever looks at ack_s.
    logic ack_m;
    logic ack_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= host_bootdata_ack;
            ack_s <= ack_m;
        end
    end

    // All outputs are registered. They are assigned on the transition
    // into the state that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            rst_cnt           <= '0;
            to_cnt            <= '0;
            idx               <= '0;
            src_addr          <= '0;
            src_rd            <= 1'b0;
            host_bootdata     <= '0;
            host_bootdata_req <= 1'b0;
            host_reset        <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            src_rd <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_RESET;
                        rst_cnt    <= RW'(RESET_CYCLES);
                        idx        <= '0;
                        host_reset <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end

                S_RESET: begin
                    // The exit fires in the cycle the counter would reach
                    // zero. This keeps host_reset high for exactly
                    // RESET_CYCLES cycles.
                    if (rst_cnt == RW'(1)) begin
                        state      <= S_FETCH;
                        host_reset <= 1'b0;
                        src_rd     <= 1'b1;
                        src_addr   <= idx;
                    end else begin
                        rst_cnt <= rst_cnt - RW'(1);
                    end
                end

                S_FETCH: begin
                    state <= S_WAIT_SRC;
                end

                S_WAIT_SRC: begin
                    // No timeout here. The source latency is unbounded.
                    if (src_valid) begin
                        state             <= S_REQ;
                        host_bootdata     <= src_data;
                        host_bootdata_req <= 1'b1;
                        to_cnt            <= TW'(ACK_TIMEOUT);
                    end
                end

                S_REQ: begin
                    if (ack_s) begin
                        state             <= S_RELEASE;
                        host_bootdata_req <= 1'b0;
                        to_cnt            <= TW'(ACK_TIMEOUT);
                    end else if (to_cnt == '0) begin
                        state             <= S_ERROR;
                        host_bootdata_req <= 1'b0;
                        busy              <= 1'b0;
                        error             <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TW'(1);
                    end
                end

                S_RELEASE: begin
                    if (!ack_s) begin
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // Go straight into FETCH. The strobe and the
                            // next address are issued together here.
                            state    <= S_FETCH;
                            idx      <= idx + 13'd1;
                            src_rd   <= 1'b1;
                            src_addr <= idx + 13'd1;
                        end
                    end else if (to_cnt == '0) begin
                        state <= S_ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bootdata_streamer.sv
// tb/tb_bootdata_streamer.sv - directed self-checking bench for bootdata_streamer

module tb_bootdata_streamer;

    localparam int ROM_BYTES    = 64;
    localparam int NW           = ROM_BYTES / 4;
    localparam int RESET_CYCLES = 16;
    localparam int ACK_TIMEOUT  = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [12:0] src_addr;
    logic        src_rd;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack = 1'b0;
    logic        host_reset;
    logic        busy;
    logic        done;
    logic        error;

    int vectors = 0;
    int miscompares = 0;

    bootdata_streamer #(
        .ROM_BYTES   (ROM_BYTES),
        .RESET_CYCLES(RESET_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .src_addr         (src_addr),
        .src_rd           (src_rd),
        .src_valid        (src_valid),
        .src_data         (src_data),
        .host_bootdata    (host_bootdata),
        .host_bootdata_req(host_bootdata_req),
        .host_bootdata_ack(host_bootdata_ack),
        .host_reset       (host_reset),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_word(input int n);
        logic [12:0] a;
        a = 13'(n);
        return {3'b000, a, 3'b000, a};
    endfunction

    // Source model: answers each src_rd after 1..src_lat_max cycles.
    int          src_lat_max = 1;
    int          src_lat;
    logic [12:0] src_a;
    always begin
        @(posedge clk);
        if (src_rd === 1'b1) begin
            src_a   = src_addr;
            src_lat = $urandom_range(src_lat_max, 1);
            repeat (src_lat - 1) @(posedge clk);
            #1;
            src_data  = {3'b000, src_a, 3'b000, src_a};
            src_valid = 1'b1;
            @(posedge clk);
            #1;
            src_valid = 1'b0;
        end
    end

    // Observers: fetch strobes and host_bootdata stability while req is high.
    int          last_rd_cyc = 0;
    int          rd_count = 0;
    int          unstable = 0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (src_rd === 1'b1) begin
            last_rd_cyc = cyc;
            rd_count++;
        end
        if (prev_req && host_bootdata_req === 1'b1 && host_bootdata !== prev_data)
            unstable++;
        prev_req  = (host_bootdata_req === 1'b1);
        prev_data = host_bootdata;
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        host_bootdata_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Responder for one word: waits for req, acks after dly cycles, and
    // releases ack hold cycles after req drops.
    task automatic do_word(input int dly, input int hold, output logic [31:0] w,
                           output int rise_c, output int rfall_c, output int afall_c,
                           output bit ok);
        ok = 1'b0; w = '0; rise_c = 0; rfall_c = 0; afall_c = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (host_bootdata_req === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        repeat (dly) @(negedge clk);
        host_bootdata_ack = 1'b1;
        rise_c = cyc;
        w = host_bootdata;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_bootdata_req === 1'b0) begin ok = 1'b1; rfall_c = cyc; break; end
        end
        if (!ok) return;
        repeat (hold) @(negedge clk);
        host_bootdata_ack = 1'b0;
        afall_c = cyc;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vectors++;
        if ({host_bootdata, host_bootdata_req, host_reset, src_rd, src_addr, busy, done, error} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got bootdata=%h req=%b hrst=%b rd=%b addr=%h busy=%b done=%b err=%b, expected all 0",
                     host_bootdata, host_bootdata_req, host_reset, src_rd, src_addr, busy, done, error);
        end
    endtask

    task automatic test_reset_pulse();
        int bad_hr;
        int bad_rd;
        apply_reset();
        bad_hr = 0;
        bad_rd = 0;
        pulse_start();
        // Now at cycle 1 relative to the start cycle.
        for (int i = 1; i <= 17; i++) begin
            if (i > 1) @(negedge clk);
            if (host_reset !== (i <= 16)) bad_hr++;
            if (src_rd !== (i == 17)) bad_rd++;
        end
        vectors++;
        if (bad_hr != 0) begin
            miscompares++;
            $display("FAIL reset_pulse_host_reset: got %0d wrong cycles, expected 0 (high for cycles 1..16)", bad_hr);
        end
        vectors++;
        if (bad_rd != 0) begin
            miscompares++;
            $display("FAIL reset_pulse_src_rd: got %0d wrong cycles, expected 0 (strobe only at cycle 17)", bad_rd);
        end
        vectors++;
        if (src_addr !== 13'h0000) begin
            miscompares++;
            $display("FAIL reset_pulse_addr: got %h expected 0000", src_addr);
        end
    endtask

    task automatic test_full_stream();
        logic [31:0] w;
        int rc, fc, ac, k, bad;
        bit ok;
        apply_reset();
        bad = 0;
        ac = 0;
        pulse_start();
        for (int n = 0; n < NW; n++) begin
            do_word(5, 0, w, rc, fc, ac, ok);
            if (!ok || w !== exp_word(n)) begin
                bad++;
                $display("FAIL full_stream_word%0d: got %h ok=%0d expected %h", n, w, ok, exp_word(n));
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_stream: got %0d bad words, expected 0", bad);
        end
        for (k = 0; k < 10; k++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        vectors++;
        if (cyc - ac !== 3) begin
            miscompares++;
            $display("FAIL done_latency: got %0d cycles after ack fall, expected 3", cyc - ac);
        end
        vectors++;
        if ({done, busy, error, host_bootdata_req} !== 4'b1000) begin
            miscompares++;
            $display("FAIL done_status: got done/busy/err/req=%b expected 1000", {done, busy, error, host_bootdata_req});
        end
        vectors++;
        if (host_bootdata !== exp_word(NW - 1)) begin
            miscompares++;
            $display("FAIL last_word: got %h expected %h", host_bootdata, exp_word(NW - 1));
        end
    endtask

    task automatic test_four_phase();
        logic [31:0] w;
        int rc, fc, ac, snap;
        bit ok;
        apply_reset();
        unstable = 0;
        pulse_start();
        do_word(2, 17, w, rc, fc, ac, ok);
        snap = rd_count;
        vectors++;
        if (!ok || fc - rc !== 3) begin
            miscompares++;
            $display("FAIL req_fall_latency: got %0d ok=%0d expected 3", fc - rc, ok);
        end
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (last_rd_cyc - ac !== 3) begin
            miscompares++;
            $display("FAIL fetch_after_ack_fall: got %0d expected 3", last_rd_cyc - ac);
        end
        vectors++;
        if (rd_count - snap !== 1) begin
            miscompares++;
            $display("FAIL fetch_count: got %0d strobes expected 1", rd_count - snap);
        end
        do_word(0, 20, w, rc, fc, ac, ok);
        vectors++;
        if (!ok || w !== exp_word(1)) begin
            miscompares++;
            $display("FAIL four_phase_word1: got %h expected %h", w, exp_word(1));
        end
        vectors++;
        if (unstable !== 0) begin
            miscompares++;
            $display("FAIL bootdata_stable: got %0d changes while req high, expected 0", unstable);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        int rc, fc, ac, r, k;
        bit ok;
        apply_reset();
        pulse_start();
        for (int n = 0; n < 3; n++) do_word(1, 0, w, rc, fc, ac, ok);
        r = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (host_bootdata_req === 1'b1) begin r = cyc; break; end
        end
        for (k = 0; k < 200; k++) begin
            if (error === 1'b1) break;
            @(negedge clk);
        end
        vectors++;
        if (r < 0 || cyc - r !== ACK_TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles (r=%0d), expected %0d", cyc - r, r, ACK_TIMEOUT + 1);
        end
        vectors++;
        if ({error, busy, done, host_bootdata_req} !== 4'b1000) begin
            miscompares++;
            $display("FAIL error_status: got err/busy/done/req=%b expected 1000", {error, busy, done, host_bootdata_req});
        end
        pulse_start();
        vectors++;
        if ({host_reset, busy, error} !== 3'b110) begin
            miscompares++;
            $display("FAIL restart_after_error: got hrst/busy/err=%b expected 110", {host_reset, busy, error});
        end
        for (int i = 0; i < 40; i++) begin
            if (src_rd === 1'b1) break;
            @(negedge clk);
        end
        vectors++;
        if (src_rd !== 1'b1 || src_addr !== 13'h0000) begin
            miscompares++;
            $display("FAIL restart_fetch_addr: got rd=%b addr=%h expected rd=1 addr=0000", src_rd, src_addr);
        end
        do_word(0, 0, w, rc, fc, ac, ok);
        vectors++;
        if (!ok || w !== exp_word(0)) begin
            miscompares++;
            $display("FAIL restart_word0: got %h expected %h", w, exp_word(0));
        end
    endtask

    task automatic test_midstream_reset();
        logic [31:0] w;
        int rc, fc, ac;
        bit ok, seen;
        apply_reset();
        pulse_start();
        for (int n = 0; n < 10; n++) do_word(0, 0, w, rc, fc, ac, ok);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (host_bootdata_req === 1'b1) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen || host_bootdata !== exp_word(10)) begin
            miscompares++;
            $display("FAIL word10_req: got %h seen=%0d expected %h", host_bootdata, seen, exp_word(10));
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({host_bootdata, host_bootdata_req, host_reset, src_rd, src_addr, busy, done, error} !== '0) begin
            miscompares++;
            $display("FAIL midstream_reset_outputs: got bootdata=%h req=%b hrst=%b rd=%b addr=%h busy=%b done=%b err=%b, expected all 0",
                     host_bootdata, host_bootdata_req, host_reset, src_rd, src_addr, busy, done, error);
        end
        reset = 1'b0;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            if (src_rd === 1'b1) break;
            @(negedge clk);
        end
        vectors++;
        if (src_rd !== 1'b1 || src_addr !== 13'h0000) begin
            miscompares++;
            $display("FAIL midstream_restart_addr: got rd=%b addr=%h expected rd=1 addr=0000", src_rd, src_addr);
        end
        do_word(0, 0, w, rc, fc, ac, ok);
        vectors++;
        if (!ok || w !== exp_word(0)) begin
            miscompares++;
            $display("FAIL midstream_restart_word0: got %h expected %h", w, exp_word(0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int rc, fc, ac, bad, snap, hr;
        bit ok;
        apply_reset();
        src_lat_max = 7;
        bad = 0;
        hr = 0;
        pulse_start();
        repeat (RESET_CYCLES) @(negedge clk);
        snap = rd_count;
        for (int n = 0; n < NW; n++) begin
            do_word(n % 3, n % 2, w, rc, fc, ac, ok);
            if (!ok || w !== exp_word(n)) begin
                bad++;
                $display("FAIL b2b_word%0d: got %h ok=%0d expected %h", n, w, ok, exp_word(n));
            end
            if (n == 7) begin
                // Stray source data in RELEASE must not reach host_bootdata.
                src_data  = 32'hDEAD_BEEF;
                src_valid = 1'b1;
                @(negedge clk);
                src_valid = 1'b0;
                vectors++;
                if (host_bootdata !== exp_word(7)) begin
                    miscompares++;
                    $display("FAIL stray_src_valid: got %h expected %h", host_bootdata, exp_word(7));
                end
            end else begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (host_reset !== 1'b0) hr++;
        end
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL b2b_order: got %0d bad words expected 0", bad);
        end
        vectors++;
        if (hr != 0 || rd_count - snap !== NW) begin
            miscompares++;
            $display("FAIL b2b_start_ignored: got hrst_hits=%0d fetches=%0d expected 0 and %0d", hr, rd_count - snap, NW);
        end
        vectors++;
        if ({done, busy, error} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_done: got done/busy/err=%b expected 100", {done, busy, error});
        end
        src_lat_max = 1;
    endtask

    initial begin
        test_reset();
        test_reset_pulse();
        test_full_stream();
        test_four_phase();
        test_timeout();
        test_midstream_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
